// File: rtl/fma_mult_pipe.sv
// Three-stage pipelined floating-point multiplier (the multiply half of an FMA).
// S1 unpacks, classifies and multiplies the mantissas; S2 normalises and forms
// guard/sticky; S3 rounds, packs and registers the result with its flags.
// Subnormal inputs are read as signed zero and underflow flushes to signed zero.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake (x, y, negp, roundmode)
//   x, y                operands {sign, exp[NE], frac[NF]}
//   negp                invert the product sign
//   roundmode           00 RZ, 01 RNE, 10 RM (toward -inf), 11 RP (toward +inf)
//   out_valid/out_ready result handshake
//   product             rounded result
//   flags               {NV, OF, UF, NX}
module fma_mult_pipe #(
  parameter int unsigned NE = 5,
  parameter int unsigned NF = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NE+NF:0]   x,
  input  logic [NE+NF:0]   y,
  input  logic             negp,
  input  logic [1:0]       roundmode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NE+NF:0]   product,
  output logic [3:0]       flags
);

  localparam int unsigned W    = 1 + NE + NF;
  localparam int unsigned PW   = 2 * NF + 2;
  localparam int unsigned EW   = NE + 2;
  localparam int unsigned BIAS = (2 ** (NE - 1)) - 1;

  localparam logic [1:0] RM_RZ  = 2'b00;
  localparam logic [1:0] RM_RNE = 2'b01;
  localparam logic [1:0] RM_RDN = 2'b10;
  localparam logic [1:0] RM_RUP = 2'b11;

  localparam logic [W-1:0]    QNAN    = {1'b0, {NE{1'b1}}, 1'b1, {(NF - 1){1'b0}}};
  localparam logic [W-2:0]    INF_MAG = {{NE{1'b1}}, {NF{1'b0}}};
  localparam logic [W-2:0]    MAX_MAG = {{(NE - 1){1'b1}}, 1'b0, {NF{1'b1}}};
  localparam logic signed [EW-1:0] EMAX  = EW'((2 ** NE) - 1);
  localparam logic signed [EW-1:0] EZERO = '0;

  // Single advance enable: the whole pipe moves unless the output is stalled.
  logic adv;
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  // ---------------------------------------------------------------- S1 logic
  logic                 s1n_sign;
  logic                 s1n_spec;
  logic                 s1n_spec_nv;
  logic [W-1:0]         s1n_spec_res;
  logic signed [EW-1:0] s1n_exp;
  logic [PW-1:0]        s1n_prod;

  // Unpack, classify and multiply; special operands resolve fully here.
  always_comb begin
    logic [NE-1:0] ex, ey;
    logic [NF-1:0] fx, fy;
    logic x_zero, y_zero, x_inf, y_inf, x_nan, y_nan, x_snan, y_snan;

    ex = x[W-2:NF];
    ey = y[W-2:NF];
    fx = x[NF-1:0];
    fy = y[NF-1:0];

    // Zero exponent covers subnormals, which are read as zero.
    x_zero = (ex == '0);
    y_zero = (ey == '0);
    x_inf  = (&ex) & (fx == '0);
    y_inf  = (&ey) & (fy == '0);
    x_nan  = (&ex) & (|fx);
    y_nan  = (&ey) & (|fy);
    x_snan = x_nan & ~fx[NF-1];
    y_snan = y_nan & ~fy[NF-1];

    s1n_sign     = x[W-1] ^ y[W-1] ^ negp;
    s1n_spec     = 1'b1;
    s1n_spec_nv  = 1'b0;
    s1n_spec_res = '0;
    if (x_nan | y_nan) begin
      s1n_spec_res = QNAN;
      s1n_spec_nv  = x_snan | y_snan;
    end else if ((x_zero & y_inf) | (x_inf & y_zero)) begin
      s1n_spec_res = QNAN;
      s1n_spec_nv  = 1'b1;
    end else if (x_inf | y_inf) begin
      s1n_spec_res = {s1n_sign, INF_MAG};
    end else if (x_zero | y_zero) begin
      s1n_spec_res = {s1n_sign, {(W - 1){1'b0}}};
    end else begin
      s1n_spec = 1'b0;
    end

    s1n_exp  = $signed(EW'(ex) + EW'(ey) - EW'(BIAS));
    s1n_prod = PW'({1'b1, fx}) * PW'({1'b1, fy});
  end

  // ---------------------------------------------------------------- S1 regs
  logic                 s1_v;
  logic                 s1_sign;
  logic                 s1_spec;
  logic                 s1_spec_nv;
  logic [W-1:0]         s1_spec_res;
  logic [1:0]           s1_rm;
  logic signed [EW-1:0] s1_exp;
  logic [PW-1:0]        s1_prod;

  // ---------------------------------------------------------------- S2 logic
  logic                 s2n_guard;
  logic                 s2n_sticky;
  logic [NF-1:0]        s2n_frac;
  logic signed [EW-1:0] s2n_exp;

  // Normalise: a product in [2,4) shifts right one place and bumps the exponent.
  always_comb begin
    logic msb;
    msb = s1_prod[PW-1];
    if (msb) begin
      s2n_frac   = s1_prod[PW-2:NF+1];
      s2n_guard  = s1_prod[NF];
      s2n_sticky = |s1_prod[NF-1:0];
    end else begin
      s2n_frac   = s1_prod[PW-3:NF];
      s2n_guard  = s1_prod[NF-1];
      s2n_sticky = |s1_prod[NF-2:0];
    end
    s2n_exp = s1_exp + $signed(EW'(msb));
  end

  // ---------------------------------------------------------------- S2 regs
  logic                 s2_v;
  logic                 s2_sign;
  logic                 s2_spec;
  logic                 s2_spec_nv;
  logic [W-1:0]         s2_spec_res;
  logic [1:0]           s2_rm;
  logic signed [EW-1:0] s2_exp;
  logic [NF-1:0]        s2_frac;
  logic                 s2_guard;
  logic                 s2_sticky;

  // ---------------------------------------------------------------- S3 logic
  logic [W-1:0] res_c;
  logic [3:0]   flg_c;

  // Round, then range-check the final exponent (after any rounding carry).
  always_comb begin
    logic                 grs;
    logic                 rinc;
    logic                 ovf, unf, inf_sel;
    logic [NF:0]          frac_rnd;
    logic signed [EW-1:0] exp_fin;

    grs  = s2_guard | s2_sticky;
    rinc = 1'b0;
    case (s2_rm)
      RM_RNE:  rinc = s2_guard & (s2_sticky | s2_frac[0]);
      RM_RDN:  rinc = grs & s2_sign;
      RM_RUP:  rinc = grs & ~s2_sign;
      RM_RZ:   rinc = 1'b0;
      default: rinc = 1'b0;
    endcase

    // A carry out leaves the low NF bits zero, which is the required fraction.
    frac_rnd = {1'b0, s2_frac} + (NF + 1)'(rinc);
    exp_fin  = s2_exp + $signed(EW'(frac_rnd[NF]));
    ovf      = (exp_fin >= EMAX);
    unf      = (exp_fin <= EZERO);
    inf_sel  = (s2_rm == RM_RNE) | ((s2_rm == RM_RDN) & s2_sign) |
               ((s2_rm == RM_RUP) & ~s2_sign);

    res_c = {s2_sign, exp_fin[NE-1:0], frac_rnd[NF-1:0]};
    flg_c = {3'b000, grs};
    if (s2_spec) begin
      res_c = s2_spec_res;
      flg_c = {s2_spec_nv, 3'b000};
    end else if (ovf) begin
      res_c = {s2_sign, inf_sel ? INF_MAG : MAX_MAG};
      flg_c = 4'b0101;
    end else if (unf) begin
      res_c = {s2_sign, {(W - 1){1'b0}}};
      flg_c = 4'b0011;
    end
  end

  // Valid bits and output register: cleared by reset, frozen while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_v      <= 1'b0;
      s2_v      <= 1'b0;
      out_valid <= 1'b0;
      product   <= '0;
      flags     <= '0;
    end else if (adv) begin
      s1_v      <= in_valid;
      s2_v      <= s1_v;
      out_valid <= s2_v;
      if (s2_v) begin
        product <= res_c;
        flags   <= flg_c;
      end
    end
  end

  // Datapath registers; contents are qualified by the valid bits above.
  always_ff @(posedge clk) begin
    if (adv) begin
      s1_sign     <= s1n_sign;
      s1_spec     <= s1n_spec;
      s1_spec_nv  <= s1n_spec_nv;
      s1_spec_res <= s1n_spec_res;
      s1_rm       <= roundmode;
      s1_exp      <= s1n_exp;
      s1_prod     <= s1n_prod;

      s2_sign     <= s1_sign;
      s2_spec     <= s1_spec;
      s2_spec_nv  <= s1_spec_nv;
      s2_spec_res <= s1_spec_res;
      s2_rm       <= s1_rm;
      s2_exp      <= s2n_exp;
      s2_frac     <= s2n_frac;
      s2_guard    <= s2n_guard;
      s2_sticky   <= s2n_sticky;
    end
  end

endmodule
